// File: rtl/entry_shaper_pkg.sv
// -----------------------------------------------------------------------------
// entry_shaper_pkg
// Shared lab constants: keypad-entry shaper FSM encoding, debounce default,
// and the digit/length constants used by the downstream password checker.
// -----------------------------------------------------------------------------
package entry_shaper_pkg;

    // Default number of consecutive stable cycles to accept a key level change.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Password checker constants: width of one digit and digits per password.
    localparam int DEFAULT_DIGIT_W = 4;
    localparam int PASS_LEN        = 4;

    // Shaper FSM: released, one-cycle strobe, wait for release.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_HOLD  = 2'd2
    } shaper_state_t;

endpackage

// File: rtl/entry_shaper_debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
// Two-flop synchronizer followed by a consecutive-cycle debounce counter.
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   raw_n   raw active-low pushbutton, asynchronous to clk
//   stable  debounced active-low level (1 = released)
// -----------------------------------------------------------------------------
module debouncer
    import entry_shaper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic stable
);

    // Counter sized for the largest legal DEBOUNCE_CYCLES (255).
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer resets to "released" so a key held through reset
            // is seen as a fresh falling level once rst drops.
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1,
            // giving a real two-stage pipeline instead of one flop.
            sync1 <= raw_n;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th differing sample in a row.
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/entry_shaper.sv
// -----------------------------------------------------------------------------
// entry_shaper
// Turns a bouncy active-low pushbutton into exactly one strobe per accepted
// press, capturing the slide-switch digit and counting entries.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   key_n        raw active-low pushbutton, asynchronous, may bounce
//   sw_digit     raw slide-switch digit
//   passnum      digit captured at the most recent accepted press
//   p_enter      one-cycle registered strobe per accepted press
//   entry_count  accepted presses since reset, modulo 16
// -----------------------------------------------------------------------------
module entry_shaper
    import entry_shaper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DIGIT_W         = DEFAULT_DIGIT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_n,
    input  logic [DIGIT_W-1:0] sw_digit,
    output logic [DIGIT_W-1:0] passnum,
    output logic               p_enter,
    output logic [3:0]         entry_count
);

    logic          stable_n;
    shaper_state_t state;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .rst   (rst),
        .raw_n (key_n),
        .stable(stable_n)
    );

    // Single registered FSM: outputs are assigned on the same edge as the
    // state transition so p_enter is glitch-free and aligned with S_PULSE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            p_enter     <= 1'b0;
            passnum     <= '0;
            entry_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!stable_n) begin
                        state       <= S_PULSE;
                        p_enter     <= 1'b1;
                        passnum     <= sw_digit;
                        entry_count <= entry_count + 4'd1;
                    end
                end
                S_PULSE: begin
                    state   <= S_HOLD;
                    p_enter <= 1'b0;
                end
                S_HOLD: begin
                    if (stable_n) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    p_enter <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entry_shaper.sv
// -----------------------------------------------------------------------------
// tb_entry_shaper
// Self-checking bench for entry_shaper with DEBOUNCE_CYCLES = 4. A behavioural
// model states the rules directly: a key level is accepted once the
// synchronized key (two cycles late) has shown it for D consecutive samples;
// one strobe is issued per accepted press, re-armed by an accepted release.
// -----------------------------------------------------------------------------
module tb_entry_shaper;

    localparam int D  = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_n = 1'b1;
    logic [DW-1:0] sw_digit = '0;
    logic [DW-1:0] passnum;
    logic          p_enter;
    logic [3:0]    entry_count;

    entry_shaper #(
        .DEBOUNCE_CYCLES(D),
        .DIGIT_W        (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .sw_digit   (sw_digit),
        .passnum    (passnum),
        .p_enter    (p_enter),
        .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic          m_dly0, m_dly1;   // synchronizer delay line
    logic          m_win [D];        // most recent D synchronized samples
    logic          m_stable;
    logic          m_armed;
    logic          m_p;
    logic [DW-1:0] m_num;
    logic [3:0]    m_cnt;

    // Strobe tracking for the directed scenarios.
    int edge_no      = 0;
    int strobes      = 0;
    int first_strobe = -1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dly0   = 1'b1;
        m_dly1   = 1'b1;
        for (int i = 0; i < D; i++) m_win[i] = 1'b1;
        m_stable = 1'b1;
        m_armed  = 1'b1;
        m_p      = 1'b0;
        m_num    = '0;
        m_cnt    = '0;
    endtask

    task automatic model_edge(input logic k, input logic [DW-1:0] sw);
        logic sample;
        logic all_diff;
        sample = m_dly1;
        // Strobe decision uses the accepted level as it was before this edge.
        if (m_armed && !m_stable) begin
            m_p     = 1'b1;
            m_armed = 1'b0;
            m_num   = sw;
            m_cnt   = m_cnt + 4'd1;
        end else begin
            m_p = 1'b0;
            if (m_stable) m_armed = 1'b1;
        end
        for (int i = D - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = sample;
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) if (m_win[i] == m_stable) all_diff = 1'b0;
        if (all_diff) m_stable = sample;
        m_dly1 = m_dly0;
        m_dly0 = k;
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, compare shortly after it.
    task automatic step(input logic k, input logic [DW-1:0] sw, input logic r);
        @(negedge clk);
        key_n    = k;
        sw_digit = sw;
        rst      = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(k, sw);
        #1;
        edge_no++;
        check("p_enter", int'(p_enter), int'(m_p));
        check("passnum", int'(passnum), int'(m_num));
        check("entry_count", int'(entry_count), int'(m_cnt));
        if (p_enter) begin
            strobes++;
            if (first_strobe < 0) first_strobe = edge_no;
        end
    endtask

    task automatic hold(input logic k, input logic [DW-1:0] sw, input int n);
        for (int i = 0; i < n; i++) step(k, sw, 1'b0);
    endtask

    task automatic clear_trk();
        strobes      = 0;
        first_strobe = -1;
    endtask

    int e0;
    logic rk;
    logic [DW-1:0] rsw;

    initial begin
        model_reset();

        // Reset state.
        hold(1'b1, 4'd0, 0);
        step(1'b1, 4'd7, 1'b1);
        step(1'b1, 4'd7, 1'b1);
        check("rst_p_enter", int'(p_enter), 0);
        check("rst_passnum", int'(passnum), 0);
        check("rst_count", int'(entry_count), 0);
        hold(1'b1, 4'd7, 8);

        // Clean press, sw = 3.
        clear_trk();
        e0 = edge_no + 1;
        hold(1'b0, 4'd3, 20);
        check("clean_strobes", strobes, 1);
        check("clean_latency", first_strobe - e0, D + 2);
        check("clean_passnum", int'(passnum), 3);
        check("clean_count", int'(entry_count), 1);
        hold(1'b1, 4'd3, 10);

        // Bounce: low 2, high 1, low 3, high 1, then steady low.
        clear_trk();
        hold(1'b0, 4'd6, 2);
        hold(1'b1, 4'd6, 1);
        hold(1'b0, 4'd6, 3);
        hold(1'b1, 4'd6, 1);
        e0 = edge_no + 1;
        hold(1'b0, 4'd6, 15);
        check("bounce_strobes", strobes, 1);
        check("bounce_latency", first_strobe - e0, D + 2);
        hold(1'b1, 4'd6, 10);

        // Held key, switch changes 5 -> 9 after the strobe.
        clear_trk();
        hold(1'b0, 4'd5, 10);
        hold(1'b0, 4'd9, 40);
        check("held_strobes", strobes, 1);
        check("held_passnum", int'(passnum), 5);
        hold(1'b1, 4'd9, 10);

        // Wrap-around: 17 presses from reset.
        step(1'b1, 4'd0, 1'b1);
        clear_trk();
        for (int i = 0; i < 17; i++) begin
            hold(1'b0, 4'(i), 10);
            check("wrap_count", int'(entry_count), (i + 1) % 16);
            hold(1'b1, 4'(i), 10);
        end
        check("wrap_strobes", strobes, 17);

        // Reset during S_HOLD with the key still held.
        hold(1'b0, 4'd2, 12);
        step(1'b0, 4'd2, 1'b1);
        check("midrst_p_enter", int'(p_enter), 0);
        check("midrst_passnum", int'(passnum), 0);
        check("midrst_count", int'(entry_count), 0);
        clear_trk();
        e0 = edge_no + 1;
        hold(1'b0, 4'd8, 15);
        check("midrst_strobes", strobes, 1);
        check("midrst_latency", first_strobe - e0, D + 2);
        check("midrst_passnum2", int'(passnum), 8);

        // Short release (3 cycles) between presses: no second strobe.
        hold(1'b1, 4'd8, 10);
        hold(1'b0, 4'd4, 15);
        clear_trk();
        hold(1'b1, 4'd4, 3);
        hold(1'b0, 4'd11, 20);
        check("short_rel_strobes", strobes, 0);
        check("short_rel_passnum", int'(passnum), 4);
        hold(1'b1, 4'd4, 10);

        // Randomized key runs, switch values and occasional reset.
        rk = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int run;
            rk  = ~rk;
            run = (($urandom % 4) == 0) ? int'($urandom_range(D + 2, 14))
                                        : int'($urandom_range(1, D + 1));
            for (int j = 0; j < run; j++) begin
                rsw = DW'($urandom);
                step(rk, rsw, (($urandom % 200) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/entry_shaper.md
ENTRY_SHAPER -- requirements
Module: entry_shaper

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, sets consecutive stable cycles needed to accept a key level change; legal range 2..255.
REQ-002 Parameter DIGIT_W, default 4, sets the width of the switch digit.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 key_n  input  1  raw pushbutton, active-low, asynchronous to clk, may bounce.
REQ-006 sw_digit  input  DIGIT_W  raw slide-switch digit value.
REQ-007 passnum  output  DIGIT_W  digit captured at the most recent accepted press; feeds the password checker.
REQ-008 p_enter  output  1  one-cycle strobe per accepted press; feeds the password checker.
REQ-009 entry_count  output  4  number of accepted presses since reset, modulo 16.

Function
REQ-010 key_n SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Debounce: a counter SHALL increment each cycle the synchronized key differs from the stable level and clear to 0 whenever they agree.
REQ-012 When the counter reaches DEBOUNCE_CYCLES, the stable level SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-013 Shaper FSM states: S_IDLE (released), S_PULSE (strobe), S_HOLD (await release).
REQ-014 S_IDLE -> S_PULSE when stable level is pressed; otherwise remain.
REQ-015 S_PULSE -> S_HOLD unconditionally after one cycle.
REQ-016 S_HOLD -> S_IDLE when stable level is released; otherwise remain.
REQ-017 p_enter SHALL be a registered output, high exactly while in S_PULSE.
REQ-018 passnum SHALL load sw_digit on the edge entering S_PULSE and hold it until the next such edge.
REQ-019 entry_count SHALL increment on the edge entering S_PULSE, wrapping 15 -> 0.
REQ-020 Latency: for key_n low from before edge k and held, p_enter SHALL rise on edge k+DEBOUNCE_CYCLES+2 and fall one edge later.
REQ-021 Bounce or glitch shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no strobe and no stable-level change.
REQ-022 A press held for any duration SHALL produce exactly one strobe; re-strobing requires an accepted release.
REQ-023 sw_digit changes while in S_PULSE's successor states SHALL NOT affect passnum.
REQ-024 A release shorter than DEBOUNCE_CYCLES between presses SHALL be ignored, so no second strobe occurs.

Reset
REQ-025 With rst high at an edge: synchronizer flops = 1 (released), stable level = released, debounce counter = 0, FSM = S_IDLE.
REQ-026 Output reset values: passnum = 0, p_enter = 0, entry_count = 0.
REQ-027 rst SHALL override all other activity, including mid-strobe or mid-debounce.
REQ-028 A key held through reset release SHALL be treated as a new press and strobe after the REQ-020 latency, measured from the first edge with rst low.

Structure
REQ-029 FSM state encodings and the default DEBOUNCE_CYCLES value SHALL live in the shared lab package or include, alongside the password checker's constants.
REQ-030 Synchronizer plus debounce counter SHALL be a sub-module named debouncer.
REQ-031 Its ports SHALL be clk, rst, raw_n and stable, parameterized by DEBOUNCE_CYCLES.
REQ-032 FSM, capture register and counter SHALL reside in entry_shaper.

Verification (DEBOUNCE_CYCLES = 4)
REQ-033 Clean press: rst low; key_n low at edge 10, held 20 cycles; sw_digit = 3.
  Required: p_enter high only during the cycle after edge 16; passnum = 3 from edge 16; entry_count = 1.
REQ-034 Bounce: key_n low 2 cycles, high 1, low 3, high 1, then low steady.
  Required: exactly one strobe, 6 edges after the steady low begins; no earlier strobe.
REQ-035 Held key plus switch change: key held 50 cycles; sw_digit changes 5 -> 9 after the strobe.
  Required: passnum stays 5; single strobe.
REQ-036 Wrap-around: 17 accepted presses separated by 10-cycle releases.
  Required: entry_count steps 1..15, 0, 1; 17 strobes.
REQ-037 Reset mid-operation: rst high for 1 edge during S_HOLD.
  Required: all outputs = 0 on that edge; the still-held key strobes once, 6 edges after rst falls.
REQ-038 Short release: key released for 3 cycles, then pressed again.
  Required: no second strobe.
